// File: rtl/float_stim_pkg.sv
// Shared types and helpers for the IEEE-754 stimulus generator.
package float_stim_pkg;

  localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

  typedef enum logic [1:0] {MODE_RAW, MODE_NORMAL, MODE_SPECIAL, MODE_WALK} mode_e;
  typedef enum logic [2:0] {CL_ZERO, CL_DENORM, CL_NORMAL, CL_INF, CL_NAN} cls_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} fsm_e;

  function automatic logic [63:0] xs64_next(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  // word is zero-extended; exp_w/man_w select the field layout
  function automatic cls_e fp_class(input logic [63:0] word, input int exp_w, input int man_w);
    logic [63:0] emask, mmask, e, m;
    emask = (64'd1 << exp_w) - 64'd1;
    mmask = (64'd1 << man_w) - 64'd1;
    e = (word >> man_w) & emask;
    m = word & mmask;
    if (e == 64'd0) return (m == 64'd0) ? CL_ZERO : CL_DENORM;
    if (e == emask) return (m == 64'd0) ? CL_INF : CL_NAN;
    return CL_NORMAL;
  endfunction

endpackage

// File: rtl/float_stim_lane.sv
// One operand channel: xorshift64 state, mode shaping and class decode.
module float_stim_lane
  import float_stim_pkg::*;
#(
  parameter int EXP_W  = 11,
  parameter int MAN_W  = 52,
  parameter int NUM_CH = 2,
  parameter int CH     = 0,
  parameter int LEN_W  = 16,
  localparam int W     = EXP_W + MAN_W + 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             adv,
  input  mode_e            mode,
  input  logic [63:0]      seed,
  input  logic [W-1:0]     base,
  input  logic [LEN_W-1:0] count,
  output logic [W-1:0]     word,
  output logic [2:0]       cls
);

  localparam logic [EXP_W-1:0] EMAX = '1;

  logic [63:0]      st, init;
  logic [W-1:0]     r, walk;
  logic             s;
  logic [EXP_W-1:0] e, e_n;
  logic [MAN_W-1:0] m;

  always_comb begin
    init = seed ^ (64'(CH) * GOLDEN);
    if (init == 64'd0) init = GOLDEN;
  end

  always_ff @(posedge clk) begin
    if (rst)      st <= GOLDEN;
    else if (ld)  st <= init;
    else if (adv) st <= xs64_next(st);
  end

  assign r    = st[W-1:0];
  assign s    = r[W-1];
  assign e    = r[W-2 -: EXP_W];
  assign m    = r[MAN_W-1:0];
  assign walk = W'(64'(base) + 64'(count) * 64'(NUM_CH) + 64'(CH));

  // pull zero/max exponents into the normal range
  always_comb begin
    e_n = e;
    if (e == '0)        e_n = EXP_W'(1);
    else if (e == EMAX) e_n = EMAX - EXP_W'(1);
  end

  always_comb begin
    word = r;
    case (mode)
      MODE_NORMAL: word = {s, e_n, m};
      MODE_SPECIAL: begin
        case (st[63:61])
          3'd0:    word = {s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
          3'd1:    word = {s, EMAX, {MAN_W{1'b0}}};
          3'd2:    word = {s, EMAX, 1'b1, m[MAN_W-2:0]};
          3'd3:    word = {s, {EXP_W{1'b0}}, m | MAN_W'(m == '0)};
          default: word = {s, e_n, m};
        endcase
      end
      MODE_WALK: word = walk;
      default:   word = r;
    endcase
  end

  assign cls = fp_class(64'(word), EXP_W, MAN_W);

endmodule

// File: rtl/float_stim_gen.sv
// Multi-channel IEEE-754 stimulus source with valid/ready output and length-limited runs.
module float_stim_gen
  import float_stim_pkg::*;
#(
  parameter int pPrecision = 2,
  parameter int pWidthExp  = 8,
  parameter int pWidthMan  = 23,
  parameter int pNumCh     = 2,
  parameter int pLenW      = 16,
  localparam int pExpW     = (pPrecision == 1) ? 8  : (pPrecision == 2) ? 11 : pWidthExp,
  localparam int pManW     = (pPrecision == 1) ? 23 : (pPrecision == 2) ? 52 : pWidthMan,
  localparam int pW        = pExpW + pManW + 1
)(
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Start,
  input  logic [1:0]           iv_Mode,
  input  logic [63:0]          iv_Seed,
  input  logic [pLenW-1:0]     iv_Len,
  input  logic                 i_Abort,
  input  logic                 i_Ready,
  output logic                 o_Valid,
  output logic [pNumCh*pW-1:0] ov_FltOut,
  output logic [pNumCh*3-1:0]  ov_Class,
  output logic                 o_Busy,
  output logic                 o_Done
);

  fsm_e                         state_q, state_d;
  mode_e                        mode_q;
  logic [pLenW-1:0]             len_q, count_q, count_nx;
  logic [pW-1:0]                base_q;
  logic                         valid_q, valid_d, done_q, done_d, load, seed_ld;
  logic [pNumCh-1:0][pW-1:0]    lane_word, flt_q;
  logic [pNumCh-1:0][2:0]       lane_cls, cls_q;

  assign count_nx = count_q + 1'b1;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // abort outranks both the handshake and the final acceptance
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    load    = 1'b0;
    seed_ld = 1'b0;
    case (state_q)
      ST_IDLE: if (i_Start) begin
        seed_ld = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_Abort) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if ((!valid_q || i_Ready) && (len_q == '0 || count_q != len_q)) begin
          load    = 1'b1;
          valid_d = 1'b1;
          if (len_q != '0 && count_nx == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_Abort) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (valid_q && i_Ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      flt_q   <= '0;
      cls_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      base_q  <= '0;
      mode_q  <= MODE_RAW;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      if (seed_ld) begin
        mode_q  <= mode_e'(iv_Mode);
        len_q   <= iv_Len;
        base_q  <= iv_Seed[pW-1:0];
        count_q <= '0;
      end
      if (load) begin
        flt_q   <= lane_word;
        cls_q   <= lane_cls;
        count_q <= count_nx;
      end
    end
  end

  for (genvar c = 0; c < pNumCh; c++) begin : g_lane
    float_stim_lane #(
      .EXP_W(pExpW), .MAN_W(pManW), .NUM_CH(pNumCh), .CH(c), .LEN_W(pLenW)
    ) u_lane (
      .clk(i_Clk), .rst(i_Rst), .ld(seed_ld), .adv(load), .mode(mode_q),
      .seed(iv_Seed), .base(base_q), .count(count_q),
      .word(lane_word[c]), .cls(lane_cls[c])
    );
  end

  assign o_Valid   = valid_q;
  assign ov_FltOut = flt_q;
  assign ov_Class  = cls_q;
  assign o_Busy    = (state_q != ST_IDLE);
  assign o_Done    = done_q;

endmodule

// File: tb/tb_float_stim_gen.sv
// Bench: single- and double-precision generators driven in lockstep against a stream-level model.
module tb_float_stim_gen;

  localparam logic [63:0] GOLD = 64'h9E3779B97F4A7C15;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, ready = 1'b1;
  logic [1:0]   mode = 2'd0;
  logic [63:0]  seed = 64'd0;
  logic [15:0]  len = 16'd0;
  logic         v_sp, busy_sp, done_sp, v_dp, busy_dp, done_dp;
  logic [63:0]  flt_sp;
  logic [127:0] flt_dp;
  logic [5:0]   cls_sp, cls_dp;

  always #5 clk = ~clk;

  float_stim_gen #(.pPrecision(1), .pNumCh(2), .pLenW(16)) u_sp (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .iv_Mode(mode), .iv_Seed(seed), .iv_Len(len),
    .i_Abort(abort), .i_Ready(ready), .o_Valid(v_sp), .ov_FltOut(flt_sp), .ov_Class(cls_sp),
    .o_Busy(busy_sp), .o_Done(done_sp));

  float_stim_gen #(.pPrecision(2), .pNumCh(2), .pLenW(16)) u_dp (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .iv_Mode(mode), .iv_Seed(seed), .iv_Len(len),
    .i_Abort(abort), .i_Ready(ready), .o_Valid(v_dp), .ov_FltOut(flt_dp), .ov_Class(cls_dp),
    .o_Busy(busy_dp), .o_Done(done_dp));

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    return y ^ (y << 17);
  endfunction

  // Expected word for beat k of channel c, built from the field rules
  function automatic logic [63:0] shape(input logic [63:0] st, input logic [1:0] md, input int k,
                                        input int c, input logic [63:0] sd, input int ew, input int mw);
    logic [63:0] wm, em, r, s, e, m;
    int w;
    w  = ew + mw + 1;
    wm = (64'd1 << w) - 64'd1;
    em = (64'd1 << ew) - 64'd1;
    r  = st & wm;
    s  = (r >> (w - 1)) & 64'd1;
    e  = (r >> mw) & em;
    m  = r & ((64'd1 << mw) - 64'd1);
    if (md == 2'd0) return r;
    if (md == 2'd3) return (sd + 64'(k) * 64'd2 + 64'(c)) & wm;
    if (md == 2'd2 && st[63:61] == 3'd0) begin e = 0; m = 0; end
    else if (md == 2'd2 && st[63:61] == 3'd1) begin e = em; m = 0; end
    else if (md == 2'd2 && st[63:61] == 3'd2) begin e = em; m = m | (64'd1 << (mw - 1)); end
    else if (md == 2'd2 && st[63:61] == 3'd3) begin e = 0; if (m == 0) m = 1; end
    else if (e == 0) e = 1;
    else if (e == em) e = em - 1;
    return (s << (w - 1)) | (e << mw) | m;
  endfunction

  function automatic logic [63:0] cls_of(input logic [63:0] wd, input int ew, input int mw);
    logic [63:0] e, m, em;
    em = (64'd1 << ew) - 64'd1;
    e  = (wd >> mw) & em;
    m  = wd & ((64'd1 << mw) - 64'd1);
    if (e == 0) return (m == 0) ? 64'd0 : 64'd1;
    if (e == em) return (m == 0) ? 64'd3 : 64'd4;
    return 64'd2;
  endfunction

  // Stream model: L beats loaded, A beats accepted, one-deep output slot
  bit          m_act = 1'b0, m_done = 1'b0;
  int          L = 0, A = 0, m_len = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [63:0] m_seed = 64'd0;
  logic [63:0] mst [2];
  logic [63:0] rec_sp[$], rec_d0[$], rec_d1[$];
  int          cls_seen [5];
  int          nan_bad = 0, den_bad = 0, norm_bad = 0;

  initial for (int i = 0; i < 5; i++) cls_seen[i] = 0;

  always @(posedge clk) begin : model
    bit acc;
    logic [63:0] w;
    int k;
    if (rst) begin
      m_act = 0; m_done = 0; L = 0; A = 0;
    end else begin
      m_done = 0;
      if (m_act && abort) begin
        m_act = 0; L = 0; A = 0;
      end else if (m_act) begin
        acc = (L > A) && ready;
        if (acc) begin
          rec_sp.push_back(flt_sp);
          rec_d0.push_back(flt_dp[63:0]);
          rec_d1.push_back(flt_dp[127:64]);
          for (int c = 0; c < 2; c++) begin
            w = flt_dp[c*64 +: 64];
            k = int'(cls_dp[c*3 +: 3]);
            if (m_mode == 2'd2) begin
              if (k < 5) cls_seen[k]++;
              if (k == 4 && !w[51]) nan_bad++;
              if (k == 1 && w[51:0] == 52'd0) den_bad++;
            end
            if (m_mode == 2'd1 && (w[62:52] == 11'h000 || w[62:52] == 11'h7FF || k != 2)) norm_bad++;
          end
          A++;
          for (int c = 0; c < 2; c++) mst[c] = xs(mst[c]);
          if (m_len != 0 && A == m_len) begin
            m_act = 0; m_done = 1; L = 0; A = 0;
          end
        end
        if (m_act && L == A && (m_len == 0 || L < m_len)) L++;
      end else if (start) begin
        m_act = 1; L = 0; A = 0;
        m_mode = mode; m_seed = seed; m_len = int'(len);
        for (int c = 0; c < 2; c++) begin
          mst[c] = seed ^ (64'(c) * GOLD);
          if (mst[c] == 64'd0) mst[c] = GOLD;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic mv;
    if (chk_en) begin
      mv = m_act && (L > A);
      chk("valid_sp", 64'(v_sp), 64'(mv));
      chk("valid_dp", 64'(v_dp), 64'(mv));
      chk("busy_sp", 64'(busy_sp), 64'(m_act));
      chk("busy_dp", 64'(busy_dp), 64'(m_act));
      chk("done_sp", 64'(done_sp), 64'(m_done));
      chk("done_dp", 64'(done_dp), 64'(m_done));
      if (mv) begin
        for (int c = 0; c < 2; c++) begin
          chk("word_sp", 64'(flt_sp[c*32 +: 32]), shape(mst[c], m_mode, A, c, m_seed, 8, 23));
          chk("class_sp", 64'(cls_sp[c*3 +: 3]), cls_of(64'(flt_sp[c*32 +: 32]), 8, 23));
          chk("word_dp", flt_dp[c*64 +: 64], shape(mst[c], m_mode, A, c, m_seed, 11, 52));
          chk("class_dp", 64'(cls_dp[c*3 +: 3]), cls_of(flt_dp[c*64 +: 64], 11, 52));
        end
      end
    end
  end

  task automatic start_run(input logic [1:0] md, input logic [63:0] sd, input logic [15:0] ln);
    @(negedge clk);
    rec_sp.delete(); rec_d0.delete(); rec_d1.delete();
    mode = md; seed = sd; len = ln; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    while (!done_sp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(done_sp), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input string nm);
    chk({nm, "_flt_sp"}, flt_sp, 64'd0);
    chk({nm, "_flt_dp"}, flt_dp[63:0] | flt_dp[127:64], 64'd0);
    chk({nm, "_cls"}, 64'({cls_sp, cls_dp}), 64'd0);
    chk({nm, "_ctl"}, 64'({v_sp, v_dp, busy_sp, busy_dp, done_sp, done_dp}), 64'd0);
  endtask

  task automatic check_walk(input string nm);
    logic [63:0] exp3 [3];
    exp3[0] = 64'h3F8000013F800000;
    exp3[1] = 64'h3F8000033F800002;
    exp3[2] = 64'h3F8000053F800004;
    chk({nm, "_beats"}, 64'(rec_sp.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk({nm, "_lit"}, (i < rec_sp.size()) ? rec_sp[i] : 64'hDEAD, exp3[i]);
  endtask

  initial begin : stim
    logic [63:0] qa[$], qz[$];
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check_idle_zero("reset");

    // 1: walk, steady ready
    start_run(2'd3, 64'h3F800000, 16'd3);
    wait_done(20, "t1_done");
    check_walk("t1");

    // 2: backpressure after the first beat
    start_run(2'd3, 64'h3F800000, 16'd3);
    n = 0;
    while (rec_sp.size() < 1 && n < 20) begin @(negedge clk); n++; end
    ready = 1'b0;
    repeat (4) @(negedge clk);
    ready = 1'b1;
    wait_done(20, "t2_done");
    check_walk("t2");

    // 3: special-weighted double stream
    start_run(2'd2, 64'h00C0FFEE, 16'd10000);
    wait_done(10100, "t3_done");
    for (int i = 0; i < 5; i++) chk("t3_class_seen", 64'(cls_seen[i] > 0), 64'd1);
    chk("t3_nan_msb", 64'(nan_bad), 64'd0);
    chk("t3_denorm_man", 64'(den_bad), 64'd0);

    // 4: normals only
    start_run(2'd1, 64'hBEEF, 16'd10000);
    wait_done(10100, "t4_done");
    chk("t4_normal", 64'(norm_bad), 64'd0);

    // 5: determinism and seed substitution
    start_run(2'd0, 64'h1234, 16'd20);
    wait_done(40, "t5a_done");
    qa = rec_d0;
    start_run(2'd0, 64'h1234, 16'd20);
    wait_done(40, "t5b_done");
    chk("t5_len", 64'(rec_d0.size()), 64'(qa.size()));
    for (int i = 0; i < 20; i++)
      chk("t5_repeat", (i < rec_d0.size()) ? rec_d0[i] : 64'hDEAD, (i < qa.size()) ? qa[i] : 64'hBEEF);
    start_run(2'd0, 64'd0, 16'd4);
    wait_done(20, "t5c_done");
    qz = rec_d0;
    chk("t5_seed0_ch0", (qz.size() > 0) ? qz[0] : 64'd0, GOLD);
    chk("t5_seed0_ch1", (rec_d1.size() > 0) ? rec_d1[0] : 64'd0, GOLD);
    chk("t5_seed0_sp", (rec_sp.size() > 0) ? 64'(rec_sp[0][31:0]) : 64'd0, 64'h7F4A7C15);
    start_run(2'd0, GOLD, 16'd4);
    wait_done(20, "t5d_done");
    for (int i = 0; i < 4; i++)
      chk("t5_gold_eq", (i < rec_d0.size()) ? rec_d0[i] : 64'hDEAD, (i < qz.size()) ? qz[i] : 64'hBEEF);
    start_run(2'd0, 64'd1, 16'd2);
    wait_done(20, "t5e_done");
    chk("t5_seed1_b0", (rec_d0.size() > 0) ? rec_d0[0] : 64'd0, 64'd1);
    chk("t5_seed1_b1", (rec_d0.size() > 1) ? rec_d0[1] : 64'd0, 64'h40822041);

    // 6: abort a free run, then reset while draining
    start_run(2'd0, 64'h55AA, 16'd0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_abort_valid", 64'({v_sp, v_dp}), 64'd0);
    chk("t6_abort_busy", 64'({busy_sp, busy_dp, done_sp}), 64'd0);
    ready = 1'b0;
    start_run(2'd0, 64'h77, 16'd1);
    repeat (3) @(negedge clk);
    chk("t6_drain_held", 64'({v_dp, busy_dp}), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("t6_rst");
    rst = 1'b0;
    ready = 1'b1;
    start_run(2'd3, 64'h3F800000, 16'd3);
    wait_done(20, "t6_fresh_done");
    check_walk("t6_fresh");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
